// File: rtl/mulu_result_ser_pkg.sv
// mulu_result_ser_pkg: shared widths, state encodings and handshake polarity for the result serializer
package mulu_result_ser_pkg;
  localparam int P_WIDTH = 6;
  localparam int FRAME_W = P_WIDTH + 1;
  localparam int CNT_W = $clog2(FRAME_W);
  localparam logic READY_TRUE = 1'b1;
  typedef enum logic {ST_IDLE = 1'b0, ST_SHIFT = 1'b1} state_t;
endpackage

// File: rtl/mulu_result_ser_if.sv
// mulu_result_ser_if: product-word handshake plus serial frame outputs
interface mulu_result_ser_if;
  import mulu_result_ser_pkg::*;
  logic in_valid;
  logic in_ready;
  logic [P_WIDTH-1:0] in_p;
  logic in_s;
  logic bit_en;
  logic sout;
  logic sframe;
  logic sstart;
  logic busy;
  modport master(output in_valid, in_p, in_s, bit_en, input in_ready, sout, sframe, sstart, busy);
  modport slave(input in_valid, in_p, in_s, bit_en, output in_ready, sout, sframe, sstart, busy);
endinterface

// File: rtl/mulu_result_ser_sync_fifo.sv
// sync_fifo: power-of-two depth FIFO with registered occupancy count
module sync_fifo #(
  parameter int WIDTH = 7,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);
  localparam int AW = $clog2(DEPTH);
  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0] r_wr, r_rd;
  logic [AW:0] r_cnt;
  logic w_push, w_pop;
  assign full = r_cnt == (AW+1)'(DEPTH);
  assign empty = r_cnt == '0;
  assign w_push = push & !full;
  assign w_pop = pop & !empty;
  assign dout = r_mem[r_rd];
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_wr <= '0;
      r_rd <= '0;
      r_cnt <= '0;
    end else begin
      r_wr <= r_wr + AW'(w_push);
      r_rd <= r_rd + AW'(w_pop);
      r_cnt <= r_cnt + (AW+1)'(w_push) - (AW+1)'(w_pop);
    end
  always_ff @(posedge clk)
    if (w_push) r_mem[r_wr] <= din;
endmodule

// File: rtl/mulu_result_ser.sv
// mulu_result_ser: buffers product words and shifts each out MSB-first as a
// FRAME_W-bit serial frame paced by bit_en, with back-to-back frames when queued
module mulu_result_ser
  import mulu_result_ser_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input logic clk,
  input logic rst_n,
  mulu_result_ser_if.slave s
);
  state_t r_state;
  logic [FRAME_W-1:0] r_shift, w_head;
  logic [CNT_W-1:0] r_cnt;
  logic r_sstart, r_busy, w_full, w_empty, w_push, w_pop, w_last;
  assign s.in_ready = w_full ? ~READY_TRUE : READY_TRUE;
  assign w_push = s.in_valid & s.in_ready;
  assign w_last = s.bit_en & (r_cnt == CNT_W'(FRAME_W - 1));
  // IDLE loads without waiting for bit_en; SHIFT reloads only on the last bit
  assign w_pop = !w_empty & ((r_state == ST_IDLE) | w_last);
  sync_fifo #(.WIDTH(FRAME_W), .DEPTH(DEPTH)) u_fifo (
    .clk(clk), .rst_n(rst_n), .push(w_push), .din({s.in_s, s.in_p}),
    .pop(w_pop), .dout(w_head), .full(w_full), .empty(w_empty)
  );
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_shift <= '0;
      r_cnt <= '0;
      r_sstart <= 1'b0;
      r_busy <= 1'b0;
    end else begin
      r_busy <= !w_empty | (r_state == ST_SHIFT);
      if (w_pop) begin
        r_state <= ST_SHIFT;
        r_shift <= w_head;
        r_cnt <= '0;
        r_sstart <= 1'b1;
      end else if (r_state == ST_SHIFT && s.bit_en) begin
        r_state <= w_last ? ST_IDLE : ST_SHIFT;
        r_shift <= w_last ? '0 : r_shift << 1;
        r_cnt <= w_last ? '0 : r_cnt + CNT_W'(1);
        r_sstart <= 1'b0;
      end
    end
  assign s.sout = r_shift[FRAME_W-1];
  assign s.sframe = r_state == ST_SHIFT;
  assign s.sstart = r_sstart;
  assign s.busy = r_busy;
endmodule

// File: doc/mulu_result_ser.md
Name: mulu_result_ser

Overview:
Downstream stage of the unsigned multiplier array. It accepts each product word (P_WIDTH bits plus the sign bit) over a valid/ready handshake and buffers it in a small FIFO. Each word is then shifted out as a fixed-length serial frame on a single output pin, paced by an external bit-rate strobe. This makes results observable on the narrow tile output bus without re-running the multiplier.

Parameters:
- P_WIDTH, 6, product width; matches the multiplier's P output width.
- DEPTH, 2, FIFO entries; power of two, at least 2.
- FRAME_W, P_WIDTH+1, bits per frame (sign bit plus product); derived, not overridable.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  a product word is presented on in_p/in_s.
- in_ready  output  1  FIFO can accept a word.
- in_p  input  P_WIDTH  product from the multiplier.
- in_s  input  1  sign bit from the multiplier (tie 0 when unsigned).
- bit_en  input  1  single-cycle bit-rate strobe; serializer advances only on cycles where it is high.
- sout  output  1  serial data, registered.
- sframe  output  1  high while a frame is on sout, registered.
- sstart  output  1  high during the first bit of every frame.
- busy  output  1  FIFO non-empty or a frame is in progress.

Behaviour:
- Reset (async assert, sync release) sets:
  - sout=0, sframe=0, sstart=0, busy=0, in_ready=1.
  - FIFO pointers and count = 0, state = IDLE, bit counter = 0.
- Handshake:
  - A word is pushed on any rising edge where in_valid & in_ready.
  - in_ready = !full, decoded from registered count. There is no combinational path from in_valid to in_ready.
  - When full, in_ready=0 even if a pop occurs in the same cycle; no full-time pass-through.
  - in_valid is allowed to drop without a transfer; the block holds no state about un-accepted words.
- FIFO:
  - DEPTH entries of FRAME_W bits, stored as {in_s, in_p}.
  - Pointers wrap modulo DEPTH; count ranges 0..DEPTH.
  - A simultaneous push and pop leaves count unchanged; both pointers advance.
- Serializer FSM:
  - IDLE: sframe=0, sstart=0, sout=0.
    - If the FIFO is non-empty, pop the head into the shift register, clear the bit counter and go to SHIFT.
    - The first bit (in_s) appears on sout the cycle after the pop, with sframe=1 and sstart=1.
    - This transition does not wait for bit_en.
  - SHIFT: bit order is MSB-first (in_s, then p[P_WIDTH-1] down to p[0]).
    - On bit_en with bit counter < FRAME_W-1: shift left, increment the counter, clear sstart.
    - On bit_en with bit counter == FRAME_W-1 and FIFO non-empty: pop and reload immediately, counter=0, sstart=1, stay in SHIFT. Frames run back-to-back with no gap bit.
    - On bit_en with bit counter == FRAME_W-1 and FIFO empty: go to IDLE; sframe and sout fall on the next edge.
    - Without bit_en, all outputs hold.
- Each bit is held on sout for exactly one bit_en period. The first bit is held from load until the first bit_en.
- busy = (count != 0) | (state == SHIFT), registered.
- Latency: accepted word into an empty, idle block gives its first bit on sout 2 clocks after the accepting edge.
- Reset mid-frame aborts the frame: outputs drop within the async-assert time and FIFO contents are discarded.
- bit_en held high continuously gives one bit per clock; this is a legal configuration.

Decomposition:
- Shared package/include (alongside global.vh/config.vh):
  - P_WIDTH and FRAME_W defines.
  - FSM state encodings ST_IDLE=1'b0, ST_SHIFT=1'b1.
  - READY_TRUE polarity define.
- One sub-module: sync_fifo (parameters WIDTH, DEPTH).
  - Ports: clk, rst_n, push, din, pop, dout, full, empty.
- The serializer FSM stays in the top module.

Test Plan:
- Reset: assert rst_n=0 mid-frame with bit_en=1 -> sout=0, sframe=0, busy=0, in_ready=1 immediately; the next frame starts only after a fresh push.
- Single word: push in_p=6'b100011 (35 = 5*7), in_s=0, bit_en=1 constant -> sout sequence 0,1,0,0,0,1,1 over 7 clocks starting 2 clocks after accept; sstart high on the first bit only; sframe high for exactly 7 clocks.
- Back-to-back: push 35 then 6'b001001 (9 = 3*3) -> 14 consecutive framed bits with no gap; sstart pulses at bit 0 and bit 7.
- Backpressure: bit_en=0, push 3 words with DEPTH=2 -> first word loaded into shift register, next two fill FIFO, in_ready=0 after the third accept; a fourth in_valid is held off until a pop, then accepted; no word is lost or duplicated.
- Slow rate: bit_en once every 4 clocks, push 6'b111111 with in_s=1 -> every bit held 4 clocks; frame ends, FSM returns to IDLE, busy falls one clock after the last bit_en.
- Simultaneous push/pop: FIFO full; the last bit_en of a frame coincides with in_valid -> in_ready=0 that cycle (no pass-through); count drops by 1 and in_ready=1 the next cycle.
